ctrl_state_seq: RTL and testbench
=================================

Name: ctrl_state_seq

Overview:
- State register and control-strobe sequencer for the multi-cycle CPU control unit.
- Consumes the combinational next-state value from the next-state logic and registers it as the current state.
- Feeds the current state back to the next-state logic.
- Generates per-state datapath strobes (PC write, IR write, register write, data memory read/write), a sticky halt, an illegal-state flag and a retired-instruction counter.

Parameters:
OP_JUMP, 6'b111000, opcode that completes in ID (two-cycle instruction)
OP_HALT, 6'b111111, opcode that stops sequencing
OP_SW, 6'b100110, store opcode; data memory write in state 011
OP_LW, 6'b100111, load opcode; data memory read in state 011
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
n_state  input  3  next state from next-state logic
Opcode  input  6  opcode from instruction register; stable from ID onward
cur_state  output  3  registered current state
PCWre  output  1  PC write enable
IRWre  output  1  instruction register write enable
RegWre  output  1  register file write enable
mRD  output  1  data memory read enable
mWR  output  1  data memory write enable
halted  output  1  sticky halt indicator
state_err  output  1  sticky illegal-next-state flag
instr_count  output  CNT_W  number of retired instructions

Behaviour:
- State encodings:
  - IF = 3'b000
  - ID = 3'b001
  - EXE = 3'b010
  - WB = 3'b011
  - HALT = 3'b111
  - All others are illegal as inputs.
- Clock is CLK. Reset is RST, synchronous and active-high. RST has priority over every other event, including halt and illegal state.
- Reset values: cur_state=000, halted=0, state_err=0, instr_count=0. All strobes are therefore 0, except IRWre=1 because state is IF.
- Register update per edge when not in reset:
  - cur_state==HALT: hold HALT.
  - cur_state==ID and Opcode==OP_HALT: cur_state<=HALT, halted<=1. Overrides n_state.
  - n_state in {000,001,010,011}: cur_state<=n_state.
  - Otherwise: cur_state<=000, state_err<=1. state_err stays 1 until RST.
- Strobes are combinational from the registered cur_state and Opcode (zero-latency relative to cur_state):
  - IRWre = (cur_state==IF).
  - PCWre = (cur_state==WB) OR (cur_state==ID AND Opcode==OP_JUMP).
  - mRD = (cur_state==WB AND Opcode==OP_LW).
  - mWR = (cur_state==WB AND Opcode==OP_SW).
  - RegWre = (cur_state==WB AND Opcode!=OP_SW).
  - In HALT all strobes are 0, including IRWre.
- instr_count increments by 1 on every edge where PCWre==1 and RST==0. Wraps modulo 2^CNT_W with no flag.
- An instruction retires on the edge leaving its last state. Normal instructions take 4 cycles IF→ID→EXE→WB. Jump takes 2 cycles IF→ID.
- Reset mid-instruction discards the in-flight instruction: no count increment on the RST edge, even if PCWre was 1.
- Opcode changes while in IF have no effect on state. Only the value of Opcode in ID/WB is used.
- No strobe may be asserted in an X state after reset. Every output must be defined on the first cycle after RST deasserts.

Test Plan:
1. RST=1 for 2 edges, then release → cur_state=000, IRWre=1, PCWre=RegWre=mRD=mWR=0, halted=0, state_err=0, instr_count=0.
2. Opcode=6'b000000, n_state driven 001,010,011,000 → cur_state walks 000→001→010→011→000. In 011: PCWre=1, RegWre=1, mRD=mWR=0. instr_count=1 after 4 edges.
3. Opcode=OP_JUMP, n_state 001 then 000 → PCWre=1 only during state 001. Cycle returns to 000 after 2 edges; instr_count=1. Repeat with OP_LW: mRD=1, RegWre=1 in 011. Repeat with OP_SW: mWR=1, RegWre=0 in 011.
4. Opcode=OP_HALT reaching ID → next edge cur_state=111, halted=1, all strobes 0. Hold for 10 edges with arbitrary n_state: no change, instr_count frozen. Assert RST → cur_state=000, halted=0.
5. n_state=3'b101 while in EXE → next edge cur_state=000, state_err=1. Flag stays 1 through further legal cycles; cleared only by RST.
6. CNT_W=4, run 16 jump instructions → instr_count=0 after wrap. RST asserted during a WB cycle → instr_count=0, no increment on that edge.

Source files
------------

// File: rtl/ctrl_state_seq.sv
// ctrl_state_seq: current-state register and per-state datapath strobe
// generation for the multi-cycle CPU control unit. It also provides the sticky
// halt and illegal-state flags and the retired-instruction counter.
module ctrl_state_seq #(
    parameter logic [5:0] OP_JUMP = 6'b111000,
    parameter logic [5:0] OP_HALT = 6'b111111,
    parameter logic [5:0] OP_SW   = 6'b100110,
    parameter logic [5:0] OP_LW   = 6'b100111,
    parameter int         CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       n_state,
    input  logic [5:0]       Opcode,
    output logic [2:0]       cur_state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             mRD,
    output logic             mWR,
    output logic             halted,
    output logic             state_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_WB   = 3'b011,
        S_HALT = 3'b111
    } state_t;

    state_t             state_q, state_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Decode the datapath strobes from the registered state and the current opcode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        PCWre  = 1'b0;
        IRWre  = 1'b0;
        RegWre = 1'b0;
        mRD    = 1'b0;
        mWR    = 1'b0;
        unique case (state_q)
            S_IF: IRWre = 1'b1;
            S_ID: PCWre = (Opcode == OP_JUMP);
            S_WB: begin
                PCWre  = 1'b1;
                RegWre = (Opcode != OP_SW);
                mRD    = (Opcode == OP_LW);
                mWR    = (Opcode == OP_SW);
            end
            default: ;
        endcase
    end

    // Next-state selection: halt hold and halt entry win over n_state, and an
    // illegal n_state falls back to IF while raising the sticky error flag.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        err_d    = err_q;
        if (state_q == S_HALT) begin
            state_d = S_HALT;
        end else if (state_q == S_ID && Opcode == OP_HALT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
        end else if (n_state[2] == 1'b0) begin
            state_d = state_t'(n_state);
        end else begin
            state_d = S_IF;
            err_d   = 1'b1;
        end
    end

    // An instruction retires on the edge where the PC is written; the counter wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (PCWre) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, flag and counter registers; reset dominates, so an in-flight instruction is discarded.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cur_state   = state_q;
    assign halted      = halted_q;
    assign state_err   = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_state_seq.sv
// Testbench for ctrl_state_seq. Directed steps push their hand-computed
// expected outputs into a queue. A monitor compares the outputs after every
// clock edge. A second instance with a 4-bit counter checks the wrap.
module tb_ctrl_state_seq;

    localparam logic [5:0] OP_JUMP = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_ALU  = 6'b000000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  n_state = 3'b000;
    logic [5:0]  Opcode = 6'b000000;

    logic [2:0]  cur_state, cur_state4;
    logic        PCWre, IRWre, RegWre, mRD, mWR, halted, state_err;
    logic        PCWre4, IRWre4, RegWre4, mRD4, mWR4, halted4, state_err4;
    logic [15:0] instr_count;
    logic [3:0]  instr_count4;

    ctrl_state_seq #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .n_state(n_state), .Opcode(Opcode),
        .cur_state(cur_state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
        .mRD(mRD), .mWR(mWR), .halted(halted), .state_err(state_err),
        .instr_count(instr_count)
    );

    ctrl_state_seq #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .n_state(n_state), .Opcode(Opcode),
        .cur_state(cur_state4), .PCWre(PCWre4), .IRWre(IRWre4), .RegWre(RegWre4),
        .mRD(mRD4), .mWR(mWR4), .halted(halted4), .state_err(state_err4),
        .instr_count(instr_count4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  st;
        logic [5:0]  op;
        logic        h;
        logic        e;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected strobes {PCWre, IRWre, RegWre, mRD, mWR} for a state/opcode pair.
    function automatic logic [4:0] exp_strb(input logic [2:0] st, input logic [5:0] op);
        logic [4:0] s;
        case (st)
            3'b000:  s = 5'b01000;
            3'b001:  s = (op == OP_JUMP) ? 5'b10000 : 5'b00000;
            3'b011:  s = {1'b1, 1'b0, op != OP_SW, op == OP_LW, op == OP_SW};
            default: s = 5'b00000;
        endcase
        return s;
    endfunction

    // Monitor: one expectation per edge, sampled 1 ns after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cur_state",   16'(cur_state),    16'(e.st));
                check("strobes",     16'({PCWre, IRWre, RegWre, mRD, mWR}), 16'(exp_strb(e.st, e.op)));
                check("halted",      16'(halted),       16'(e.h));
                check("state_err",   16'(state_err),    16'(e.e));
                check("instr_count", instr_count,       e.cnt);
                check("cnt4",        16'(instr_count4), 16'(e.cnt[3:0]));
                check("dut4_misc",   16'({cur_state4, PCWre4, IRWre4, RegWre4, mRD4, mWR4, halted4, state_err4}),
                      16'({e.st, exp_strb(e.st, e.op), e.h, e.e}));
            end
        end
    end

    // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic [2:0] ns, input logic [5:0] op,
                        input logic [2:0] st, input logic h, input logic e, input logic [15:0] cnt);
        exp_t x;
        @(negedge CLK);
        RST     = r;
        n_state = ns;
        Opcode  = op;
        x.st = st; x.op = op; x.h = h; x.e = e; x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    initial begin
        int          wait_cyc;
        logic [15:0] c;
        // Reset held for two edges.
        step(1, 3'd0, OP_ALU, 3'd0, 0, 0, 16'd0);
        step(1, 3'd5, OP_ALU, 3'd0, 0, 0, 16'd0);
        // ALU instruction IF->ID->EXE->WB->IF.
        step(0, 3'd1, OP_ALU, 3'd1, 0, 0, 16'd0);
        step(0, 3'd2, OP_ALU, 3'd2, 0, 0, 16'd0);
        step(0, 3'd3, OP_ALU, 3'd3, 0, 0, 16'd0);
        step(0, 3'd0, OP_ALU, 3'd0, 0, 0, 16'd1);
        // Jump retires from ID.
        step(0, 3'd1, OP_JUMP, 3'd1, 0, 0, 16'd1);
        step(0, 3'd0, OP_JUMP, 3'd0, 0, 0, 16'd2);
        // Load.
        step(0, 3'd1, OP_LW, 3'd1, 0, 0, 16'd2);
        step(0, 3'd2, OP_LW, 3'd2, 0, 0, 16'd2);
        step(0, 3'd3, OP_LW, 3'd3, 0, 0, 16'd2);
        step(0, 3'd0, OP_LW, 3'd0, 0, 0, 16'd3);
        // Store.
        step(0, 3'd1, OP_SW, 3'd1, 0, 0, 16'd3);
        step(0, 3'd2, OP_SW, 3'd2, 0, 0, 16'd3);
        step(0, 3'd3, OP_SW, 3'd3, 0, 0, 16'd3);
        step(0, 3'd0, OP_SW, 3'd0, 0, 0, 16'd4);
        // Illegal n_state from EXE goes to IF with a sticky error.
        step(0, 3'd1, OP_ALU, 3'd1, 0, 0, 16'd4);
        step(0, 3'd2, OP_ALU, 3'd2, 0, 0, 16'd4);
        step(0, 3'd5, OP_ALU, 3'd0, 0, 1, 16'd4);
        // HALT opcode seen only in IF has no effect; error stays set.
        step(0, 3'd1, OP_HALT, 3'd1, 0, 1, 16'd4);
        step(0, 3'd2, OP_ALU,  3'd2, 0, 1, 16'd4);
        step(0, 3'd3, OP_ALU,  3'd3, 0, 1, 16'd4);
        step(0, 3'd0, OP_ALU,  3'd0, 0, 1, 16'd5);
        // HALT reaching ID overrides n_state, then holds for 10 edges.
        step(0, 3'd1, OP_HALT, 3'd1, 0, 1, 16'd5);
        step(0, 3'd2, OP_HALT, 3'd7, 1, 1, 16'd5);
        for (int i = 0; i < 10; i++) begin
            step(0, 3'(i), (i % 2 == 0) ? OP_JUMP : OP_SW, 3'd7, 1, 1, 16'd5);
        end
        // Reset releases halt and clears the error.
        step(1, 3'd1, OP_ALU, 3'd0, 0, 0, 16'd0);
        // 16 jumps: the 4-bit counter wraps to 0.
        c = 16'd0;
        for (int i = 0; i < 16; i++) begin
            step(0, 3'd1, OP_JUMP, 3'd1, 0, 0, c);
            c = c + 16'd1;
            step(0, 3'd0, OP_JUMP, 3'd0, 0, 0, c);
        end
        // Reset during WB discards the instruction without counting it.
        step(0, 3'd1, OP_ALU, 3'd1, 0, 0, 16'd16);
        step(0, 3'd2, OP_ALU, 3'd2, 0, 0, 16'd16);
        step(0, 3'd3, OP_ALU, 3'd3, 0, 0, 16'd16);
        step(1, 3'd0, OP_ALU, 3'd0, 0, 0, 16'd0);
        step(0, 3'd1, OP_ALU, 3'd1, 0, 0, 16'd0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge CLK);
            wait_cyc++;
        end
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
